// File: rtl/axi_shim_arb.sv
// Round-robin arbiter that shares one AXI shim request port between NumReq requesters.
// Read and write channels use independent arbiter cores; the requester index rides in the upper ID bits.

module axi_shim_arb_core #(
  parameter int unsigned NumReq         = 3,
  parameter int unsigned MaxOutstanding = 2,
  localparam int unsigned IW            = $clog2(NumReq)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [NumReq-1:0] req_i,
  input  logic              gnt_i,
  input  logic              dec_i,
  input  logic [IW-1:0]     dec_idx_i,
  output logic              req_o,
  output logic [IW-1:0]     sel_o,
  output logic [NumReq-1:0] gnt_o
);

  localparam int unsigned   CW      = $clog2(MaxOutstanding + 1);
  localparam logic [CW-1:0] MaxCnt  = CW'(MaxOutstanding);
  localparam logic [IW-1:0] LastIdx = IW'(NumReq - 1);

  logic [IW-1:0]     prio_q, prio_d;
  logic [IW-1:0]     sel_q, sel_d;
  logic              locked_q, locked_d;
  logic [NumReq-1:0] elig;
  logic [IW-1:0]     sel;
  logic [IW-1:0]     idx;
  logic              found;
  logic              grant;

  always_comb begin
    sel   = '0;
    found = 1'b0;
    idx   = prio_q;
    for (int k = 0; k < NumReq; k++) begin
      if (!found && elig[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
      idx = (idx == LastIdx) ? '0 : idx + 1'b1;
    end
    // A pending shim transaction pins the selection even if eligibility changes.
    if (locked_q) begin
      sel = sel_q;
    end
  end

  assign req_o = locked_q | (|elig);
  assign grant = req_o & gnt_i;
  assign sel_o = sel;

  always_comb begin
    prio_d   = prio_q;
    sel_d    = sel_q;
    locked_d = locked_q;
    if (grant) begin
      locked_d = 1'b0;
      prio_d   = (sel == LastIdx) ? '0 : sel + 1'b1;
    end else if (req_o) begin
      locked_d = 1'b1;
      sel_d    = sel;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prio_q   <= '0;
      sel_q    <= '0;
      locked_q <= 1'b0;
    end else begin
      prio_q   <= prio_d;
      sel_q    <= sel_d;
      locked_q <= locked_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NumReq; gi++) begin : g_cnt
      logic [CW-1:0] cnt_q, cnt_d;
      logic          inc, dec;

      assign inc         = grant & (sel == IW'(gi));
      // Guard against a stray response underflowing the counter.
      assign dec         = dec_i & (dec_idx_i == IW'(gi)) & (cnt_q != '0);
      assign gnt_o[gi]   = inc;
      assign elig[gi]    = req_i[gi] & (cnt_q < MaxCnt);

      always_comb begin
        cnt_d = cnt_q;
        if (inc && !dec) begin
          cnt_d = cnt_q + 1'b1;
        end else if (dec && !inc) begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end
    end
  endgenerate

  a_hold_while_locked: assert property (
    @(posedge clk_i) disable iff (!rst_ni) locked_q |-> req_i[sel_q]
  );

endmodule

module axi_shim_arb #(
  parameter int unsigned NumReq         = 3,
  parameter int unsigned AxiNumWords    = 4,
  parameter int unsigned AxiUserWidth   = 64,
  parameter int unsigned AxiIdWidth     = 4,
  parameter int unsigned MaxOutstanding = 2,
  localparam int unsigned BW            = $clog2(AxiNumWords),
  localparam int unsigned IW            = $clog2(NumReq),
  localparam int unsigned RW            = AxiIdWidth - IW
) (
  input  logic                                           clk_i,
  input  logic                                           rst_ni,
  // requester read side
  input  logic [NumReq-1:0]                              req_rd_req_i,
  output logic [NumReq-1:0]                              req_rd_gnt_o,
  input  logic [NumReq-1:0][63:0]                        req_rd_addr_i,
  input  logic [NumReq-1:0][BW-1:0]                      req_rd_blen_i,
  input  logic [NumReq-1:0][1:0]                         req_rd_size_i,
  input  logic [NumReq-1:0][RW-1:0]                      req_rd_id_i,
  input  logic [NumReq-1:0]                              req_rd_lock_i,
  input  logic [NumReq-1:0]                              req_rd_rdy_i,
  output logic [NumReq-1:0]                              req_rd_valid_o,
  output logic [63:0]                                    req_rd_data_o,
  output logic [AxiUserWidth-1:0]                        req_rd_user_o,
  output logic [RW-1:0]                                  req_rd_id_o,
  output logic                                           req_rd_last_o,
  output logic                                           req_rd_exokay_o,
  // requester write side
  input  logic [NumReq-1:0]                              req_wr_req_i,
  output logic [NumReq-1:0]                              req_wr_gnt_o,
  input  logic [NumReq-1:0][63:0]                        req_wr_addr_i,
  input  logic [NumReq-1:0][AxiNumWords-1:0][63:0]       req_wr_data_i,
  input  logic [NumReq-1:0][AxiNumWords-1:0][AxiUserWidth-1:0] req_wr_user_i,
  input  logic [NumReq-1:0][AxiNumWords-1:0][7:0]        req_wr_be_i,
  input  logic [NumReq-1:0][BW-1:0]                      req_wr_blen_i,
  input  logic [NumReq-1:0][1:0]                         req_wr_size_i,
  input  logic [NumReq-1:0][RW-1:0]                      req_wr_id_i,
  input  logic [NumReq-1:0]                              req_wr_lock_i,
  input  logic [NumReq-1:0][5:0]                         req_wr_atop_i,
  input  logic [NumReq-1:0]                              req_wr_rdy_i,
  output logic [NumReq-1:0]                              req_wr_valid_o,
  output logic [RW-1:0]                                  req_wr_id_o,
  output logic                                           req_wr_exokay_o,
  // shim read side
  output logic                                           rd_req_o,
  input  logic                                           rd_gnt_i,
  output logic [63:0]                                    rd_addr_o,
  output logic [BW-1:0]                                  rd_blen_o,
  output logic [1:0]                                     rd_size_o,
  output logic [AxiIdWidth-1:0]                          rd_id_o,
  output logic                                           rd_lock_o,
  output logic                                           rd_rdy_o,
  input  logic                                           rd_valid_i,
  input  logic                                           rd_last_i,
  input  logic [63:0]                                    rd_data_i,
  input  logic [AxiUserWidth-1:0]                        rd_user_i,
  input  logic [AxiIdWidth-1:0]                          rd_id_i,
  input  logic                                           rd_exokay_i,
  // shim write side
  output logic                                           wr_req_o,
  input  logic                                           wr_gnt_i,
  output logic [63:0]                                    wr_addr_o,
  output logic [AxiNumWords-1:0][63:0]                   wr_data_o,
  output logic [AxiNumWords-1:0][AxiUserWidth-1:0]       wr_user_o,
  output logic [AxiNumWords-1:0][7:0]                    wr_be_o,
  output logic [BW-1:0]                                  wr_blen_o,
  output logic [1:0]                                     wr_size_o,
  output logic [AxiIdWidth-1:0]                          wr_id_o,
  output logic                                           wr_lock_o,
  output logic [5:0]                                     wr_atop_o,
  output logic                                           wr_rdy_o,
  input  logic                                           wr_valid_i,
  input  logic [AxiIdWidth-1:0]                          wr_id_i,
  input  logic                                           wr_exokay_i
);

  localparam logic [IW-1:0] LastIdx = IW'(NumReq - 1);

  logic [IW-1:0] rd_sel, wr_sel;
  logic [IW-1:0] rd_rsp_idx, wr_rsp_idx;
  logic          rd_dec, wr_dec;

  assign rd_rsp_idx = rd_id_i[AxiIdWidth-1 -: IW];
  assign wr_rsp_idx = wr_id_i[AxiIdWidth-1 -: IW];
  assign rd_dec     = rd_valid_i & rd_rdy_o & rd_last_i;
  assign wr_dec     = wr_valid_i & wr_rdy_o;

  axi_shim_arb_core #(
    .NumReq         (NumReq),
    .MaxOutstanding (MaxOutstanding)
  ) i_rd_arb (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .req_i     (req_rd_req_i),
    .gnt_i     (rd_gnt_i),
    .dec_i     (rd_dec),
    .dec_idx_i (rd_rsp_idx),
    .req_o     (rd_req_o),
    .sel_o     (rd_sel),
    .gnt_o     (req_rd_gnt_o)
  );

  axi_shim_arb_core #(
    .NumReq         (NumReq),
    .MaxOutstanding (MaxOutstanding)
  ) i_wr_arb (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .req_i     (req_wr_req_i),
    .gnt_i     (wr_gnt_i),
    .dec_i     (wr_dec),
    .dec_idx_i (wr_rsp_idx),
    .req_o     (wr_req_o),
    .sel_o     (wr_sel),
    .gnt_o     (req_wr_gnt_o)
  );

  // Attributes are zeroed while no request is forwarded so the shim sees a quiet bus.
  always_comb begin
    rd_addr_o = '0;
    rd_blen_o = '0;
    rd_size_o = '0;
    rd_id_o   = '0;
    rd_lock_o = 1'b0;
    for (int k = 0; k < NumReq; k++) begin
      if (rd_req_o && (rd_sel == IW'(k))) begin
        rd_addr_o = req_rd_addr_i[k];
        rd_blen_o = req_rd_blen_i[k];
        rd_size_o = req_rd_size_i[k];
        rd_id_o   = {rd_sel, req_rd_id_i[k]};
        rd_lock_o = req_rd_lock_i[k];
      end
    end
  end

  always_comb begin
    wr_addr_o = '0;
    wr_data_o = '0;
    wr_user_o = '0;
    wr_be_o   = '0;
    wr_blen_o = '0;
    wr_size_o = '0;
    wr_id_o   = '0;
    wr_lock_o = 1'b0;
    wr_atop_o = '0;
    for (int k = 0; k < NumReq; k++) begin
      if (wr_req_o && (wr_sel == IW'(k))) begin
        wr_addr_o = req_wr_addr_i[k];
        wr_data_o = req_wr_data_i[k];
        wr_user_o = req_wr_user_i[k];
        wr_be_o   = req_wr_be_i[k];
        wr_blen_o = req_wr_blen_i[k];
        wr_size_o = req_wr_size_i[k];
        wr_id_o   = {wr_sel, req_wr_id_i[k]};
        wr_lock_o = req_wr_lock_i[k];
        wr_atop_o = req_wr_atop_i[k];
      end
    end
  end

  // An out-of-range owner index matches no k, so rdy stays low for it.
  always_comb begin
    rd_rdy_o = 1'b0;
    wr_rdy_o = 1'b0;
    for (int k = 0; k < NumReq; k++) begin
      if (rd_rsp_idx == IW'(k)) rd_rdy_o = req_rd_rdy_i[k];
      if (wr_rsp_idx == IW'(k)) wr_rdy_o = req_wr_rdy_i[k];
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NumReq; gi++) begin : g_rsp
      assign req_rd_valid_o[gi] = rd_valid_i & (rd_rsp_idx == IW'(gi));
      assign req_wr_valid_o[gi] = wr_valid_i & (wr_rsp_idx == IW'(gi));
    end
  endgenerate

  assign req_rd_data_o   = rd_data_i;
  assign req_rd_user_o   = rd_user_i;
  assign req_rd_id_o     = rd_id_i[RW-1:0];
  assign req_rd_last_o   = rd_last_i;
  assign req_rd_exokay_o = rd_exokay_i;
  assign req_wr_id_o     = wr_id_i[RW-1:0];
  assign req_wr_exokay_o = wr_exokay_i;

  a_rd_rsp_id: assert property (
    @(posedge clk_i) disable iff (!rst_ni) rd_valid_i |-> (rd_rsp_idx <= LastIdx)
  );
  a_wr_rsp_id: assert property (
    @(posedge clk_i) disable iff (!rst_ni) wr_valid_i |-> (wr_rsp_idx <= LastIdx)
  );

endmodule

// File: tb/tb_axi_shim_arb.sv
// Directed bench for axi_shim_arb: a per-cycle read vector table followed by
// hand-written write round-robin, lock and reset-while-locked sequences.

module tb_axi_shim_arb;

  localparam int NumReq = 3;
  localparam int NW     = 4;
  localparam int UW     = 64;
  localparam int IDW    = 4;
  localparam int BW     = 2;
  localparam int RW     = 2;

  logic clk_i = 1'b0;
  logic rst_ni;
  always #5 clk_i = ~clk_i;

  logic [NumReq-1:0]                     req_rd_req_i, req_rd_gnt_o;
  logic [NumReq-1:0][63:0]               req_rd_addr_i;
  logic [NumReq-1:0][BW-1:0]             req_rd_blen_i;
  logic [NumReq-1:0][1:0]                req_rd_size_i;
  logic [NumReq-1:0][RW-1:0]             req_rd_id_i;
  logic [NumReq-1:0]                     req_rd_lock_i, req_rd_rdy_i, req_rd_valid_o;
  logic [63:0]                           req_rd_data_o;
  logic [UW-1:0]                         req_rd_user_o;
  logic [RW-1:0]                         req_rd_id_o;
  logic                                  req_rd_last_o, req_rd_exokay_o;
  logic [NumReq-1:0]                     req_wr_req_i, req_wr_gnt_o;
  logic [NumReq-1:0][63:0]               req_wr_addr_i;
  logic [NumReq-1:0][NW-1:0][63:0]       req_wr_data_i;
  logic [NumReq-1:0][NW-1:0][UW-1:0]     req_wr_user_i;
  logic [NumReq-1:0][NW-1:0][7:0]        req_wr_be_i;
  logic [NumReq-1:0][BW-1:0]             req_wr_blen_i;
  logic [NumReq-1:0][1:0]                req_wr_size_i;
  logic [NumReq-1:0][RW-1:0]             req_wr_id_i;
  logic [NumReq-1:0]                     req_wr_lock_i;
  logic [NumReq-1:0][5:0]                req_wr_atop_i;
  logic [NumReq-1:0]                     req_wr_rdy_i, req_wr_valid_o;
  logic [RW-1:0]                         req_wr_id_o;
  logic                                  req_wr_exokay_o;
  logic                                  rd_req_o, rd_gnt_i;
  logic [63:0]                           rd_addr_o;
  logic [BW-1:0]                         rd_blen_o;
  logic [1:0]                            rd_size_o;
  logic [IDW-1:0]                        rd_id_o;
  logic                                  rd_lock_o, rd_rdy_o, rd_valid_i, rd_last_i;
  logic [63:0]                           rd_data_i;
  logic [UW-1:0]                         rd_user_i;
  logic [IDW-1:0]                        rd_id_i;
  logic                                  rd_exokay_i;
  logic                                  wr_req_o, wr_gnt_i;
  logic [63:0]                           wr_addr_o;
  logic [NW-1:0][63:0]                   wr_data_o;
  logic [NW-1:0][UW-1:0]                 wr_user_o;
  logic [NW-1:0][7:0]                    wr_be_o;
  logic [BW-1:0]                         wr_blen_o;
  logic [1:0]                            wr_size_o;
  logic [IDW-1:0]                        wr_id_o;
  logic                                  wr_lock_o;
  logic [5:0]                            wr_atop_o;
  logic                                  wr_rdy_o, wr_valid_i;
  logic [IDW-1:0]                        wr_id_i;
  logic                                  wr_exokay_i;

  axi_shim_arb #(
    .NumReq(NumReq), .AxiNumWords(NW), .AxiUserWidth(UW), .AxiIdWidth(IDW), .MaxOutstanding(2)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_rd_req_i(req_rd_req_i), .req_rd_gnt_o(req_rd_gnt_o), .req_rd_addr_i(req_rd_addr_i),
    .req_rd_blen_i(req_rd_blen_i), .req_rd_size_i(req_rd_size_i), .req_rd_id_i(req_rd_id_i),
    .req_rd_lock_i(req_rd_lock_i), .req_rd_rdy_i(req_rd_rdy_i), .req_rd_valid_o(req_rd_valid_o),
    .req_rd_data_o(req_rd_data_o), .req_rd_user_o(req_rd_user_o), .req_rd_id_o(req_rd_id_o),
    .req_rd_last_o(req_rd_last_o), .req_rd_exokay_o(req_rd_exokay_o),
    .req_wr_req_i(req_wr_req_i), .req_wr_gnt_o(req_wr_gnt_o), .req_wr_addr_i(req_wr_addr_i),
    .req_wr_data_i(req_wr_data_i), .req_wr_user_i(req_wr_user_i), .req_wr_be_i(req_wr_be_i),
    .req_wr_blen_i(req_wr_blen_i), .req_wr_size_i(req_wr_size_i), .req_wr_id_i(req_wr_id_i),
    .req_wr_lock_i(req_wr_lock_i), .req_wr_atop_i(req_wr_atop_i), .req_wr_rdy_i(req_wr_rdy_i),
    .req_wr_valid_o(req_wr_valid_o), .req_wr_id_o(req_wr_id_o), .req_wr_exokay_o(req_wr_exokay_o),
    .rd_req_o(rd_req_o), .rd_gnt_i(rd_gnt_i), .rd_addr_o(rd_addr_o), .rd_blen_o(rd_blen_o),
    .rd_size_o(rd_size_o), .rd_id_o(rd_id_o), .rd_lock_o(rd_lock_o), .rd_rdy_o(rd_rdy_o),
    .rd_valid_i(rd_valid_i), .rd_last_i(rd_last_i), .rd_data_i(rd_data_i), .rd_user_i(rd_user_i),
    .rd_id_i(rd_id_i), .rd_exokay_i(rd_exokay_i),
    .wr_req_o(wr_req_o), .wr_gnt_i(wr_gnt_i), .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o),
    .wr_user_o(wr_user_o), .wr_be_o(wr_be_o), .wr_blen_o(wr_blen_o), .wr_size_o(wr_size_o),
    .wr_id_o(wr_id_o), .wr_lock_o(wr_lock_o), .wr_atop_o(wr_atop_o), .wr_rdy_o(wr_rdy_o),
    .wr_valid_i(wr_valid_i), .wr_id_i(wr_id_i), .wr_exokay_i(wr_exokay_i)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] rd_addr(input int k);
    return 64'h1000 * (k + 1);
  endfunction
  function automatic logic [63:0] wr_addr(input int k);
    return 64'h8000_0000 + 64'h100 * k;
  endfunction
  function automatic logic [63:0] wdata(input int k, input int w);
    return 64'hD000_0000_0000_0000 | (64'(k) << 8) | 64'(w);
  endfunction

  typedef struct {
    string          name;
    logic [2:0]     req;
    logic           gnt;
    logic           rvalid;
    logic [3:0]     rid;
    logic           rlast;
    logic [2:0]     rrdy;
    logic           exp_req;
    logic [2:0]     exp_gnt;
    logic [3:0]     exp_id;
    logic [2:0]     exp_valid;
    logic           exp_rdy;
  } rd_vec_t;

  rd_vec_t rv[$];

  task automatic add_rd(input string n, input logic [2:0] req, input logic gnt, input logic rvalid,
                        input logic [3:0] rid, input logic rlast, input logic [2:0] rrdy,
                        input logic ereq, input logic [2:0] egnt, input logic [3:0] eid,
                        input logic [2:0] evalid, input logic erdy);
    rd_vec_t t;
    t.name = n; t.req = req; t.gnt = gnt; t.rvalid = rvalid; t.rid = rid; t.rlast = rlast;
    t.rrdy = rrdy; t.exp_req = ereq; t.exp_gnt = egnt; t.exp_id = eid; t.exp_valid = evalid;
    t.exp_rdy = erdy;
    rv.push_back(t);
  endtask

  task automatic zero_dynamic();
    req_rd_req_i = '0; rd_gnt_i = 1'b0; rd_valid_i = 1'b0; rd_last_i = 1'b0; rd_id_i = '0;
    req_rd_rdy_i = '0;
    req_wr_req_i = '0; wr_gnt_i = 1'b0; wr_valid_i = 1'b0; wr_id_i = '0; req_wr_rdy_i = '0;
  endtask

  task automatic do_reset();
    @(posedge clk_i); #1;
    rst_ni = 1'b0;
    zero_dynamic();
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
  endtask

  // Drive point is 1 time unit after the rising edge; sample 3 units later.
  task automatic next_cycle();
    @(posedge clk_i); #1;
  endtask

  logic [2:0] rr_exp [7];

  initial begin
    rst_ni = 1'b0;
    zero_dynamic();
    rd_data_i = 64'hCAFE_F00D_1234_5678; rd_user_i = '0; rd_exokay_i = 1'b0; wr_exokay_i = 1'b0;
    for (int k = 0; k < NumReq; k++) begin
      req_rd_addr_i[k] = rd_addr(k);
      req_rd_blen_i[k] = BW'(k);
      req_rd_size_i[k] = 2'd3;
      req_rd_lock_i[k] = 1'b0;
      req_wr_addr_i[k] = wr_addr(k);
      req_wr_blen_i[k] = 2'd3;
      req_wr_size_i[k] = 2'd3;
      req_wr_lock_i[k] = 1'b0;
      req_wr_atop_i[k] = 6'(k);
      for (int w = 0; w < NW; w++) begin
        req_wr_data_i[k][w] = wdata(k, w);
        req_wr_user_i[k][w] = '0;
        req_wr_be_i[k][w]   = 8'hF0 | 8'(k);
      end
    end
    req_rd_id_i[0] = 2'b10; req_rd_id_i[1] = 2'b01; req_rd_id_i[2] = 2'b11;
    req_wr_id_i[0] = 2'b01; req_wr_id_i[1] = 2'b10; req_wr_id_i[2] = 2'b11;

    #2;
    check("reset_rd_req", 64'(rd_req_o), 64'd0);
    check("reset_wr_req", 64'(wr_req_o), 64'd0);
    check("reset_wr_addr", wr_addr_o, 64'd0);
    next_cycle();
    rst_ni = 1'b1;

    //       name              req    g  rv rid     rl rrdy    ereq egnt   eid      evalid erdy
    add_rd("idle",            3'b000, 0, 0, 4'b0000, 0, 3'b000, 0, 3'b000, 4'b0000, 3'b000, 0);
    add_rd("single_wait",     3'b010, 0, 0, 4'b0000, 0, 3'b000, 1, 3'b000, 4'b0101, 3'b000, 0);
    add_rd("single_gnt",      3'b010, 1, 0, 4'b0000, 0, 3'b000, 1, 3'b010, 4'b0101, 3'b000, 0);
    add_rd("rr_prio2_rsp1",   3'b011, 1, 1, 4'b0101, 0, 3'b010, 1, 3'b001, 4'b0010, 3'b010, 1);
    add_rd("req2_first",      3'b100, 1, 0, 4'b0000, 0, 3'b000, 1, 3'b100, 4'b1011, 3'b000, 0);
    add_rd("req2_second",     3'b100, 1, 0, 4'b0000, 0, 3'b000, 1, 3'b100, 4'b1011, 3'b000, 0);
    add_rd("limit_rsp2",      3'b100, 0, 1, 4'b1011, 1, 3'b100, 0, 3'b000, 4'b0000, 3'b100, 1);
    add_rd("limit_released",  3'b100, 1, 0, 4'b0000, 0, 3'b000, 1, 3'b100, 4'b1011, 3'b000, 0);
    add_rd("simul_inc_dec",   3'b001, 1, 1, 4'b0010, 1, 3'b001, 1, 3'b001, 4'b0010, 3'b001, 1);
    add_rd("cnt0_still_one",  3'b001, 1, 0, 4'b0000, 0, 3'b000, 1, 3'b001, 4'b0010, 3'b000, 0);
    add_rd("cnt0_full",       3'b001, 0, 1, 4'b0101, 0, 3'b101, 0, 3'b000, 4'b0000, 3'b010, 0);

    foreach (rv[v]) begin
      next_cycle();
      req_rd_req_i = rv[v].req;  rd_gnt_i = rv[v].gnt;   rd_valid_i = rv[v].rvalid;
      rd_id_i = rv[v].rid;       rd_last_i = rv[v].rlast; req_rd_rdy_i = rv[v].rrdy;
      #3;
      $display("rd vector %0d %s", v, rv[v].name);
      check({rv[v].name, ".rd_req_o"},       64'(rd_req_o),       64'(rv[v].exp_req));
      check({rv[v].name, ".req_rd_gnt_o"},   64'(req_rd_gnt_o),   64'(rv[v].exp_gnt));
      check({rv[v].name, ".rd_id_o"},        64'(rd_id_o),        64'(rv[v].exp_id));
      check({rv[v].name, ".req_rd_valid_o"}, 64'(req_rd_valid_o), 64'(rv[v].exp_valid));
      check({rv[v].name, ".rd_rdy_o"},       64'(rd_rdy_o),       64'(rv[v].exp_rdy));
      if (rv[v].exp_req) check({rv[v].name, ".rd_addr_o"}, rd_addr_o, rd_addr(int'(rv[v].exp_id[3:2])));
    end
    check("rd_data_bcast", req_rd_data_o, 64'hCAFE_F00D_1234_5678);

    // Write round robin with the shim granting every cycle; counters saturate at 2.
    do_reset();
    rr_exp = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b000};
    for (int c = 0; c < 7; c++) begin
      next_cycle();
      req_wr_req_i = 3'b111; wr_gnt_i = 1'b1;
      #3;
      $display("wr rr cycle %0d", c);
      check("rr_gnt", 64'(req_wr_gnt_o), 64'(rr_exp[c]));
      check("rr_req", 64'(wr_req_o), (c < 6) ? 64'd1 : 64'd0);
      if (c < 6) begin
        check("rr_data3", wr_data_o[3], wdata(c % 3, 3));
        check("rr_be1", 64'(wr_be_o[1]), 64'(8'hF0 | 8'(c % 3)));
      end
    end
    next_cycle();
    wr_valid_i = 1'b1; wr_id_i = 4'b0110; req_wr_rdy_i = 3'b111;
    #3;
    $display("wr B response for requester 1");
    check("b_valid", 64'(req_wr_valid_o), 64'b010);
    check("b_rdy", 64'(wr_rdy_o), 64'd1);
    check("b_id_lower", 64'(req_wr_id_o), 64'b10);
    check("b_no_gnt", 64'(req_wr_gnt_o), 64'd0);
    next_cycle();
    wr_valid_i = 1'b0;
    #3;
    check("after_b_gnt", 64'(req_wr_gnt_o), 64'b010);
    check("after_b_id", 64'(wr_id_o), 64'b0110);
    next_cycle();
    #3;
    check("after_b_full", 64'(wr_req_o), 64'd0);

    // Lock: requester 0 waits three cycles with requester 2 also requesting.
    do_reset();
    for (int c = 0; c < 3; c++) begin
      next_cycle();
      req_wr_req_i = 3'b101; wr_gnt_i = 1'b0;
      #3;
      $display("wr lock wait cycle %0d", c);
      check("lock_addr", wr_addr_o, wr_addr(0));
      check("lock_req", 64'(wr_req_o), 64'd1);
      check("lock_no_gnt", 64'(req_wr_gnt_o), 64'd0);
    end
    next_cycle();
    wr_gnt_i = 1'b1;
    #3;
    check("lock_gnt0", 64'(req_wr_gnt_o), 64'b001);
    next_cycle();
    req_wr_req_i = 3'b100;
    #3;
    check("lock_gnt2", 64'(req_wr_gnt_o), 64'b100);
    check("lock_addr2", wr_addr_o, wr_addr(2));
    check("lock_id2", 64'(wr_id_o), 64'b1011);

    // Lock on 2, then a higher-priority requester 0 arrives: selection must stay on 2.
    do_reset();
    next_cycle();
    req_wr_req_i = 3'b100; wr_gnt_i = 1'b0;
    #3;
    check("late_sel2", wr_addr_o, wr_addr(2));
    next_cycle();
    req_wr_req_i = 3'b101;
    #3;
    $display("wr late arrival while locked on 2");
    check("late_held2", wr_addr_o, wr_addr(2));
    next_cycle();
    wr_gnt_i = 1'b1;
    #3;
    check("late_gnt2", 64'(req_wr_gnt_o), 64'b100);
    next_cycle();
    req_wr_req_i = 3'b001;
    #3;
    check("late_gnt0", 64'(req_wr_gnt_o), 64'b001);
    check("late_atop0", 64'(wr_atop_o), 64'd0);

    // Reset while the read arbiter is locked on requester 1.
    do_reset();
    next_cycle();
    req_rd_req_i = 3'b001; rd_gnt_i = 1'b1;
    #3;
    check("rst_pre_gnt0", 64'(req_rd_gnt_o), 64'b001);
    next_cycle();
    req_rd_req_i = 3'b011; rd_gnt_i = 1'b0;
    #3;
    check("rst_lock_id1", 64'(rd_id_o), 64'b0101);
    next_cycle();
    #1;
    rst_ni = 1'b0;
    #1;
    $display("rd async reset while locked on 1");
    check("rst_async_sel0", 64'(rd_id_o), 64'b0010);
    req_rd_req_i = 3'b000;
    #1;
    check("rst_req_drop", 64'(rd_req_o), 64'd0);
    check("rst_gnt_zero", 64'(req_rd_gnt_o), 64'd0);
    next_cycle();
    rst_ni = 1'b1;
    for (int c = 0; c < 2; c++) begin
      next_cycle();
      req_rd_req_i = 3'b001; rd_gnt_i = 1'b1;
      #3;
      check("rst_cnt_cleared_gnt", 64'(req_rd_gnt_o), 64'b001);
    end
    next_cycle();
    rd_gnt_i = 1'b0;
    #3;
    check("rst_cnt_full", 64'(rd_req_o), 64'd0);

    next_cycle();
    zero_dynamic();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
